// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer; head is always slot 0 and is a plain register.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t slot0_q, slot1_q;
    logic [1:0]   count_q;
    logic         do_push, do_pop;

    assign full    = (count_q == 2'(DEPTH));
    assign empty   = (count_q == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    // Entry 1 (if any) advances to the head; the new word takes its place.
                    if (count_q == 2'd1) begin
                        slot0_q <= din;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= din;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= din;
                    else                 slot1_q <= din;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign head  = slot0_q;
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC, fetch buffer, redirect handling.
// Optional misaligned-redirect trap under `FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] instruction_address_o,
    input  logic [31:0] instruction_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instruction_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    output logic        misaligned_o
);

    logic [31:0]  pc_q;
    logic         pop, fetch, halted;
    logic         full, empty;
    logic [1:0]   unused_count;
    fetch_entry_t head;

    assign pop   = ~empty & id_ready_i;
    assign fetch = ~redirect_valid_i & (~full | pop) & ~halted;

    always_ff @(posedge clk_i) begin
        if (rst_i)                 pc_q <= RESET_VECTOR;
        else if (redirect_valid_i) pc_q <= redirect_pc_i & ~32'h3;
        else if (fetch)            pc_q <= pc_q + 32'd4;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    // Flag and halt are the same condition: set by a misaligned redirect,
    // cleared by any aligned one.
    always_ff @(posedge clk_i) begin
        if (rst_i)                 misaligned_q <= 1'b0;
        else if (redirect_valid_i) misaligned_q <= |redirect_pc_i[1:0];
    end

    assign halted       = misaligned_q;
    assign misaligned_o = misaligned_q;
`else
    assign halted       = 1'b0;
    assign misaligned_o = 1'b0;
`endif

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (redirect_valid_i),
        .push  (fetch),
        .pop   (pop),
        .din   ('{pc: pc_q, instr: instruction_data_i}),
        .head  (head),
        .count (unused_count),
        .full  (full),
        .empty (empty)
    );

    assign instruction_address_o = pc_q;
    assign id_valid_o            = ~empty;
    assign id_instruction_o      = empty ? NOP_INSTR : head.instr;
    assign id_pc_o               = empty ? 32'd0 : head.pc;
    assign id_pc_plus4_o         = empty ? 32'd0 : head.pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr, idata, rpc, id_instr, id_pc, id_pc4;
    logic        rv = 1'b0, rdy = 1'b0, id_valid, mis;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_halt;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    assign idata = mem(addr);

    instruction_fetch_unit dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .instruction_address_o (addr),
        .instruction_data_i    (idata),
        .redirect_valid_i      (rv),
        .redirect_pc_i         (rpc),
        .id_valid_o            (id_valid),
        .id_ready_i            (rdy),
        .id_instruction_o      (id_instr),
        .id_pc_o               (id_pc),
        .id_pc_plus4_o         (id_pc4),
        .misaligned_o          (mis)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic        v;
        logic [31:0] pc;
        v  = (q.size() > 0);
        pc = v ? q[0].pc : 32'd0;
        chk("addr",    addr,     m_pc);
        chk("valid",   {31'd0, id_valid}, {31'd0, v});
        chk("instr",   id_instr, v ? q[0].instr : 32'h0000_0013);
        chk("pc",      id_pc,    pc);
        chk("pc4",     id_pc4,   v ? pc + 32'd4 : 32'd0);
        chk("mis",     {31'd0, mis}, {31'd0, m_halt});
    endtask

    // Apply inputs for one cycle, advance the model, then check at the negedge.
    task automatic step(input logic r, input logic v, input logic [31:0] p, input logic d);
        int  sz;
        logic popm;
        rst = r; rv = v; rpc = p; rdy = d;
        sz   = q.size();
        popm = (sz > 0) && d;
        if (r) begin
            q.delete();
            m_pc   = 32'h0;
            m_halt = 1'b0;
        end else if (v) begin
            q.delete();
            m_pc = {p[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            m_halt = (p[1:0] != 2'b00);
`endif
        end else begin
            if (popm) void'(q.pop_front());
            if ((sz < 2 || popm) && !m_halt) begin
                q.push_back('{pc: m_pc, instr: mem(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        q.delete();
        m_pc = 32'h0; m_halt = 1'b0; rpc = 32'h0;

        // Reset state and first fetch
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("reset_valid", {31'd0, id_valid}, 32'd0);
        chk("reset_addr",  addr, 32'h0);
        chk("reset_instr", id_instr, 32'h0000_0013);
        chk("reset_mis",   {31'd0, mis}, 32'd0);
        step(0, 0, 0, 1);
        chk("c1_valid", {31'd0, id_valid}, 32'd1);
        chk("c1_instr", id_instr, 32'h0050_0093);
        chk("c1_pc",    id_pc, 32'h0);
        chk("c1_pc4",   id_pc4, 32'h4);

        // Stall for 5 cycles, then drain in order
        step(1, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0);
        chk("stall_addr",  addr, 32'h8);
        chk("stall_head",  id_pc, 32'h0);
        step(0, 0, 0, 1);
        chk("rel1_pc", id_pc, 32'h4);
        step(0, 0, 0, 1);
        chk("rel2_pc", id_pc, 32'h8);

        // Redirect while full and popping
        step(1, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 32'h40, 1);
        chk("rd_valid", {31'd0, id_valid}, 32'd0);
        chk("rd_addr",  addr, 32'h40);
        step(0, 0, 0, 1);
        chk("rd_pc", id_pc, 32'h40);

        // Reset beats a simultaneous redirect
        step(1, 1, 32'h80, 1);
        chk("rr_addr",  addr, 32'h0);
        chk("rr_valid", {31'd0, id_valid}, 32'd0);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        chk("wrap_pc",  id_pc,  32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc4, 32'h0);
        step(0, 0, 0, 1);
        chk("wrap_next", id_pc, 32'h0);

        // Misaligned redirect
        step(0, 1, 32'h42, 1);
        step(0, 0, 0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag",  {31'd0, mis}, 32'd1);
        chk("mis_valid", {31'd0, id_valid}, 32'd0);
        repeat (3) step(0, 0, 0, 1);
        chk("mis_hold", {31'd0, id_valid}, 32'd0);
        step(0, 1, 32'h100, 1);
        step(0, 0, 0, 1);
        chk("mis_clr", {31'd0, mis}, 32'd0);
        chk("mis_resume", id_pc, 32'h100);
`else
        chk("mis_pc",   id_pc, 32'h40);
        chk("mis_flag", {31'd0, mis}, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            p = $urandom;
            if ($urandom_range(3) == 0) p = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            step(($urandom_range(63) == 0), ($urandom_range(7) == 0), p, $urandom_range(1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
